// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the Timer bus-side controller.
// Register addresses, CTRL/STATUS bit positions and the load FSM encoding.
// Pure declarations; no logic.
package timer_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CMD    = 2'd3;

    localparam int CTRL_PERIODIC = 7;
    localparam int CTRL_IRQ_EN   = 8;

    localparam int ST_FLAG = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_BUSY = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/timer_ctrl_sync_edge.sv
// Multi-flop synchroniser with a rising-edge detector on the synchronised output.
// Latency: SYNC_STAGES cycles to the synced level; rise is combinational from it.
// No backpressure; rise is a single-cycle pulse per low-to-high transition.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    import timer_ctrl_pkg::*;

    logic [SYNC_STAGES-1:0] stg;
    logic                   prev;

    // Shift the asynchronous input through the chain and remember the last synced value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg  <= '0;
            prev <= 1'b0;
        end else begin
            stg  <= {stg[SYNC_STAGES-2:0], din};
            prev <= stg[SYNC_STAGES-1];
        end
    end

    assign rise = stg[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Register front-end for the Timer: config/reload regs, two-phase counter load, sticky irq.
// Latency: reads return next cycle; CMD write to P_EN high is 3 cycles.
// No backpressure on the register bus; load requests during a transfer queue as one pending load.
module timer_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq,
    output logic [6:0]  TMCON,
    output logic [15:0] PWDATA,
    output logic        PWRITE,
    output logic        P_SEL,
    output logic        P_EN,
    input  logic        PREADY,
    input  logic        int_flag
);
    import timer_ctrl_pkg::*;

    state_t      state, state_nxt;
    logic [8:0]  ctrl;
    logic [15:0] reload;
    logic        flag, ovr, err, load_pend;
    logic [7:0]  tcnt;
    logic        rdy_rise, int_rise;
    logic        timeout_hit;
    logic        busy, take;
    logic        wr_ctrl, wr_reload, wr_status, wr_cmd;
    logic        new_req;
    logic [15:0] rd_mux;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rdy_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (PREADY),
        .rise (rdy_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (int_flag),
        .rise (int_rise)
    );

    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
    assign wr_reload = wr_en && (addr == ADDR_RELOAD);
    assign wr_status = wr_en && (addr == ADDR_STATUS);
    assign wr_cmd    = wr_en && (addr == ADDR_CMD);

    // A CMD write and a periodic rollover in the same cycle collapse into one request.
    assign new_req = (wr_cmd && wdata[0]) || (int_rise && ctrl[CTRL_PERIODIC]);
    assign busy    = (state != IDLE);
    assign take    = (state == IDLE) && load_pend;
    assign TMCON   = ctrl[6:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and bus-phase outputs decoded straight from state so they drop on the exit edge.
    always_comb begin
        state_nxt   = state;
        P_SEL       = 1'b0;
        P_EN        = 1'b0;
        PWRITE      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (load_pend) state_nxt = SETUP;
            end
            SETUP: begin
                P_SEL     = 1'b1;
                PWRITE    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                P_SEL  = 1'b1;
                PWRITE = 1'b1;
                P_EN   = 1'b1;
                if (rdy_rise) begin
                    state_nxt = IDLE;
                end else if (tcnt == 8'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access-phase cycle counter and load-value latch; PWDATA only changes when a transfer starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt   <= '0;
            PWDATA <= '0;
        end else begin
            tcnt <= (state == ACCESS) ? tcnt + 8'd1 : 8'd0;
            if (take) PWDATA <= reload;
        end
    end

    // Configuration registers, sticky status (set beats W1C clear) and the pending-load bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            reload    <= '0;
            flag      <= 1'b0;
            ovr       <= 1'b0;
            err       <= 1'b0;
            load_pend <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl)   ctrl   <= wdata[8:0];
            if (wr_reload) reload <= wdata;

            if (int_rise)                         flag <= 1'b1;
            else if (wr_status && wdata[ST_FLAG]) flag <= 1'b0;

            if (int_rise && flag)                ovr <= 1'b1;
            else if (wr_status && wdata[ST_OVR]) ovr <= 1'b0;

            if (timeout_hit)                     err <= 1'b1;
            else if (wr_status && wdata[ST_ERR]) err <= 1'b0;

            load_pend <= (load_pend && !take) || new_req;
            irq       <= ctrl[CTRL_IRQ_EN] && flag;
        end
    end

    // Read data selection; unused bits are zero.
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:   rd_mux = {7'd0, ctrl};
            ADDR_RELOAD: rd_mux = reload;
            ADDR_STATUS: rd_mux = {12'd0, busy, err, ovr, flag};
            default:     rd_mux = '0;
        endcase
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= rd_mux;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        wr_en, rd_en;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;
    logic [6:0]  TMCON;
    logic [15:0] PWDATA;
    logic        PWRITE, P_SEL, P_EN;
    logic        PREADY;
    logic        int_flag;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pw_q[$];

    logic       auto_ready;
    logic [7:0] pen_cnt;
    logic [3:0] hold;

    timer_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .TMCON    (TMCON),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .P_SEL    (P_SEL),
        .P_EN     (P_EN),
        .PREADY   (PREADY),
        .int_flag (int_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: raise PREADY two cycles into ACCESS, hold it a few cycles, then drop it.
    always @(posedge clk) begin
        if (rst) begin
            PREADY  <= 1'b0;
            pen_cnt <= '0;
            hold    <= '0;
        end else begin
            if (auto_ready && P_EN) begin
                if (pen_cnt == 8'd1) PREADY <= 1'b1;
                pen_cnt <= pen_cnt + 8'd1;
            end else begin
                pen_cnt <= '0;
            end
            if (PREADY) begin
                if (hold == 4'd5) begin
                    PREADY <= 1'b0;
                    hold   <= '0;
                end else begin
                    hold <= hold + 4'd1;
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_en = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_int();
        int_flag = 1'b1;
        @(posedge clk); #1;
        int_flag = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d, e;
        n_cmp++;
        if ({P_SEL, P_EN, PWRITE, irq} !== 4'b0 || PWDATA !== 16'h0 || TMCON !== 7'h0 || rdata !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got sel=%0b en=%0b wr=%0b irq=%0b pwdata=%h tmcon=%h rdata=%h, want all 0",
                     P_SEL, P_EN, PWRITE, irq, PWDATA, TMCON, rdata);
        end
        exp_q.push_back(16'h0000);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL reset_status: got %h want %h", d, e); end
    endtask

    task automatic test_registers();
        logic [15:0] d, e;
        bus_write(ADDR_CTRL, 16'h01C8);
        bus_write(ADDR_RELOAD, 16'hFFF0);
        exp_q.push_back(16'h01C8);
        bus_read(ADDR_CTRL, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL read_ctrl: got %h want %h", d, e); end
        exp_q.push_back(16'hFFF0);
        bus_read(ADDR_RELOAD, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL read_reload: got %h want %h", d, e); end
        n_cmp++;
        if (TMCON !== 7'h48) begin n_bad++; $display("FAIL tmcon: got %h want 48", TMCON); end
        idle(2);
        n_cmp++;
        if (rdata !== 16'hFFF0) begin n_bad++; $display("FAIL rdata_hold: got %h want fff0", rdata); end
        exp_q.push_back(16'h0000);
        bus_read(ADDR_CMD, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL read_cmd: got %h want %h", d, e); end
    endtask

    task automatic test_manual_load();
        logic [15:0] d, e;
        bit stable;
        auto_ready = 1'b1;
        pw_q.push_back(16'hFFF0);
        bus_write(ADDR_CMD, 16'h0001);
        idle(1);
        n_cmp++;
        if ({P_SEL, P_EN, PWRITE} !== 3'b101) begin
            n_bad++; $display("FAIL setup_phase: got sel=%0b en=%0b wr=%0b want 1 0 1", P_SEL, P_EN, PWRITE);
        end
        e = pw_q.pop_front();
        n_cmp++;
        if (PWDATA !== e) begin n_bad++; $display("FAIL manual_pwdata: got %h want %h", PWDATA, e); end
        idle(1);
        n_cmp++;
        if ({P_SEL, P_EN, PWRITE} !== 3'b111) begin
            n_bad++; $display("FAIL access_phase: got sel=%0b en=%0b wr=%0b want 1 1 1", P_SEL, P_EN, PWRITE);
        end
        exp_q.push_back(16'h0008);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL busy_status: got %h want %h", d, e); end
        stable = 1'b1;
        for (int i = 0; i < 50 && P_SEL; i++) begin
            if (PWDATA !== 16'hFFF0) stable = 1'b0;
            idle(1);
        end
        n_cmp++;
        if (P_SEL !== 1'b0 || P_EN !== 1'b0) begin
            n_bad++; $display("FAIL manual_end: got sel=%0b en=%0b want 0 0", P_SEL, P_EN);
        end
        n_cmp++;
        if (!stable) begin n_bad++; $display("FAIL pwdata_stable: got changing value want fff0 held"); end
        exp_q.push_back(16'h0000);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL idle_status: got %h want %h", d, e); end
        idle(8);
    endtask

    task automatic test_periodic();
        logic [15:0] d, e;
        bus_write(ADDR_CTRL, 16'h01C0);
        bus_write(ADDR_RELOAD, 16'hFFFC);
        for (int k = 0; k < 2; k++) begin
            pw_q.push_back(16'hFFFC);
            pulse_int();
            for (int i = 0; i < 20 && !(P_SEL && !P_EN); i++) idle(1);
            e = pw_q.pop_front();
            n_cmp++;
            if (!(P_SEL && !P_EN) || PWDATA !== e) begin
                n_bad++; $display("FAIL auto_reload_%0d: got sel=%0b en=%0b pwdata=%h want setup with %h", k, P_SEL, P_EN, PWDATA, e);
            end
            n_cmp++;
            if (irq !== 1'b1) begin n_bad++; $display("FAIL periodic_irq_%0d: got %0b want 1", k, irq); end
            for (int i = 0; i < 50 && P_SEL; i++) idle(1);
            idle(8);
            exp_q.push_back(k == 0 ? 16'h0001 : 16'h0003);
            bus_read(ADDR_STATUS, d);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin n_bad++; $display("FAIL periodic_status_%0d: got %h want %h", k, d, e); end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        auto_ready = 1'b0;
        bus_write(ADDR_CMD, 16'h0001);
        for (int i = 0; i < 10 && !P_EN; i++) idle(1);
        cnt = 0;
        while (P_EN && cnt < 400) begin
            cnt++;
            if (cnt == 10) begin wr_en = 1'b1; addr = ADDR_CMD; wdata = 16'h0001; end
            @(posedge clk); #1;
            wr_en = 1'b0; wdata = '0;
        end
        n_cmp++;
        if (cnt != 255) begin n_bad++; $display("FAIL access_length: got %0d cycles want 255", cnt); end
        n_cmp++;
        if (P_SEL !== 1'b0) begin n_bad++; $display("FAIL timeout_exit: got sel=%0b want 0", P_SEL); end
        idle(1);
        n_cmp++;
        if ({P_SEL, P_EN} !== 2'b10) begin
            n_bad++; $display("FAIL queued_setup: got sel=%0b en=%0b want 1 0", P_SEL, P_EN);
        end
        for (int i = 0; i < 300 && P_SEL; i++) idle(1);
        n_cmp++;
        if (P_SEL !== 1'b0) begin n_bad++; $display("FAIL second_timeout: got sel=%0b want 0", P_SEL); end
    endtask

    task automatic test_w1c();
        logic [15:0] d, e;
        exp_q.push_back(16'h0007);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL sticky_status: got %h want %h", d, e); end
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_before_clear: got %0b want 1", irq); end
        bus_write(ADDR_STATUS, 16'h0007);
        exp_q.push_back(16'h0000);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL w1c_clear: got %h want %h", d, e); end
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_after_clear: got %0b want 0", irq); end
        bus_write(ADDR_CTRL, 16'h0100);
        pulse_int();
        idle(1);
        wr_en = 1'b1; addr = ADDR_STATUS; wdata = 16'h0001;
        @(posedge clk); #1;
        wr_en = 1'b0; wdata = '0;
        exp_q.push_back(16'h0001);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL w1c_race: got %h want %h", d, e); end
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_after_race: got %0b want 1", irq); end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] d, e;
        bit started;
        auto_ready = 1'b0;
        bus_write(ADDR_CMD, 16'h0001);
        for (int i = 0; i < 10 && !P_EN; i++) idle(1);
        bus_write(ADDR_CMD, 16'h0001);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({P_SEL, P_EN, PWRITE, irq} !== 4'b0 || rdata !== 16'h0) begin
            n_bad++; $display("FAIL reset_mid_access: got sel=%0b en=%0b wr=%0b irq=%0b rdata=%h want all 0",
                              P_SEL, P_EN, PWRITE, irq, rdata);
        end
        rst = 1'b0;
        started = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (P_SEL) started = 1'b1;
            idle(1);
        end
        n_cmp++;
        if (started) begin n_bad++; $display("FAIL pend_cleared: got transfer started want none"); end
        exp_q.push_back(16'h0000);
        bus_read(ADDR_STATUS, d);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin n_bad++; $display("FAIL status_after_reset: got %h want %h", d, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        int_flag = 1'b0; auto_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_registers();
        test_manual_load();
        test_periodic();
        test_timeout();
        test_w1c();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
